fpu_issue_ctrl: RTL and testbench
=================================

Name: fpu_issue_ctrl

Overview:
Multi-cycle issue/sequencing controller in front of the combinational FPU (add/sub, mul, div, sqrt) in the RV32IMF core. It accepts one F-extension operation at a time from decode over a valid/ready handshake and registers the operands and op-select onto the FPU inputs. It holds them stable for a per-op latency, then captures fpu_result and returns it with the destination register over a valid/ready handshake to writeback. This lets the long div/sqrt combinational paths be constrained as multicycle paths.

Parameters:
LAT_ADD, 1, cycles FPU inputs are held for add/sub before capture (>=1)
LAT_MUL, 2, hold cycles for mul (>=1)
LAT_DIV, 8, hold cycles for div (>=1)
LAT_SQRT, 8, hold cycles for sqrt (>=1)
CNT_W, 4, latency counter width; must hold max(LAT_*)-1

Ports:
clk  in  1  core clock
rst_n  in  1  synchronous active-low reset
flush  in  1  pipeline flush; aborts in-flight op
req_valid  in  1  decode has an FP op
req_ready  out  1  controller accepts op this cycle
req_op  in  3  000 add, 001 sub, 010 mul, 011 div, 100 sqrt, 101-111 illegal
req_rs1  in  32  operand A (IEEE-754 single)
req_rs2  in  32  operand B (ignored for sqrt)
req_rd  in  5  destination f-register
fpu_rs1  out  32  registered FPU operand A
fpu_rs2  out  32  registered FPU operand B
fpu_control  out  2  00 add/sub, 01 mul, 10 div, 11 sqrt
fpu_sel  out  1  0 add, 1 sub (valid when fpu_control=00)
fpu_result  in  32  combinational FPU output
rsp_valid  out  1  result available
rsp_ready  in  1  writeback takes result
rsp_data  out  32  captured result
rsp_rd  out  5  destination of result
rsp_illegal  out  1  op was illegal; rsp_data = 32'h7FC00000
busy  out  1  state != IDLE

Behaviour:
- Clock/reset: single clock clk; rst_n synchronous, active-low. Reset drives all outputs and registers to 0 except req_ready=1 (IDLE). rsp_valid=0, busy=0, fpu_* = 0.
- States: IDLE, EXEC, DONE.
- req_ready = !flush && (IDLE || (DONE && rsp_ready)).
- Accept: at an edge with req_valid && req_ready:
  - latch fpu_rs1/fpu_rs2/fpu_control/fpu_sel/rd;
  - cnt <= LAT_op-1; go to EXEC.
  - For sqrt, fpu_rs2 loads 0.
- EXEC: cnt decrements each edge. At the edge where cnt==0, rsp_data <= fpu_result and the state goes to DONE. The result is therefore sampled after exactly LAT_op cycles of stable inputs, and rsp_valid rises LAT_op edges after the accept edge.
- Illegal op: accepted normally; skips EXEC and goes straight to DONE next edge with rsp_data=32'h7FC00000 and rsp_illegal=1. FPU inputs are not updated.
- DONE:
  - rsp_valid=1; rsp_data, rsp_rd and rsp_illegal are stable until the rsp handshake.
  - On rsp_ready with no new accept: go to IDLE.
  - On rsp_ready with a simultaneous accept: go directly to EXEC (or DONE if illegal). This gives back-to-back throughput with no idle bubble.
- FPU inputs change only on accept; they hold their values in IDLE/DONE (no toggling).
- flush: overrides everything but reset. Next state is IDLE; rsp_valid drops the next cycle, the in-flight result is discarded, and the counter is cleared. A request presented in the flush cycle is not accepted. fpu_* outputs hold their values.
- Reset mid-EXEC or mid-DONE: immediate return to the reset state; no response is emitted.

Optional Feature:
FPU_PERF_CNT_EN:
- Defined: adds outputs perf_ops[31:0] (increments on each rsp handshake) and perf_stall[31:0] (increments each cycle req_valid && !req_ready). Both counters wrap at 2^32, reset to 0, and are not cleared by flush.
- Undefined: the ports and logic are absent.

Decomposition:
- Package fpu_pkg:
  - req_op encodings;
  - fpu_control codes (FPU_ADDSUB=2'b00, FPU_MUL=01, FPU_DIV=10, FPU_SQRT=11);
  - CANON_NAN=32'h7FC00000;
  - state enum.
- No sub-module: the FPU is instantiated alongside by the parent, and the latency counter and FSM stay inline.

Test Plan:
- The bench uses a behavioural FPU stub whose output is X until inputs have been stable LAT_op cycles.
- Add: rs1=0x3F800000, rs2=0x40000000, op=000 -> fpu_control=00, fpu_sel=0; rsp_valid 1 edge after accept; rsp_data=0x40400000.
- Sub then div back-to-back with rsp_ready=1: sub 0x40400000-0x3F800000 -> 0x40000000; div 0x40C00000/0x40000000 accepted in the sub's DONE cycle -> 0x40400000 exactly 8 edges later; no idle cycle.
- Sqrt 0x41C80000 (25) -> 0x40A00000 after 8 edges; fpu_rs2=0; fpu_* stable for all 8 cycles; req_ready=0 throughout.
- Backpressure: mul 0x40000000*0x40400000 with rsp_ready=0 for 5 cycles -> rsp_valid and rsp_data=0x40C00000 held; req_ready=0; perf_stall=5 when FPU_PERF_CNT_EN is defined.
- Flush in EXEC cycle 3 of a div with req_valid high -> IDLE next edge; no rsp_valid; request not taken that cycle, accepted the cycle after.
- Illegal op 101 -> rsp_valid next edge; rsp_data=0x7FC00000; rsp_illegal=1; fpu_* unchanged. Separately: rst_n low mid-EXEC -> all outputs at reset values next edge.

Source files
------------

// File: rtl/fpu_pkg.sv
// Shared encodings for the FPU issue controller: request opcodes, FPU control codes, canonical NaN.
// No logic beyond a pure legality/decode helper.
// No flow control here.
package fpu_pkg;

    localparam logic [2:0] OP_ADD  = 3'b000;
    localparam logic [2:0] OP_SUB  = 3'b001;
    localparam logic [2:0] OP_MUL  = 3'b010;
    localparam logic [2:0] OP_DIV  = 3'b011;
    localparam logic [2:0] OP_SQRT = 3'b100;

    localparam logic [1:0] FPU_ADDSUB = 2'b00;
    localparam logic [1:0] FPU_MUL    = 2'b01;
    localparam logic [1:0] FPU_DIV    = 2'b10;
    localparam logic [1:0] FPU_SQRT   = 2'b11;

    localparam logic [31:0] CANON_NAN = 32'h7FC0_0000;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_EXEC = 2'd1,
        ST_DONE = 2'd2
    } state_t;

    function automatic logic op_is_legal(input logic [2:0] op);
        return op <= OP_SQRT;
    endfunction

    function automatic logic [1:0] op_to_ctrl(input logic [2:0] op);
        case (op)
            OP_MUL:  return FPU_MUL;
            OP_DIV:  return FPU_DIV;
            OP_SQRT: return FPU_SQRT;
            default: return FPU_ADDSUB;
        endcase
    endfunction

endpackage

// File: rtl/fpu_issue_ctrl.sv
// Registers one FP op onto the combinational FPU, holds it LAT_op cycles, then captures the result.
// Latency: rsp_valid rises LAT_op edges after accept (1 edge for illegal ops); optional FPU_PERF_CNT_EN counters.
// Backpressure: result held until rsp_ready; a new op is accepted in the same cycle the result retires.
module fpu_issue_ctrl
    import fpu_pkg::*;
#(
    parameter int LAT_ADD  = 1,
    parameter int LAT_MUL  = 2,
    parameter int LAT_DIV  = 8,
    parameter int LAT_SQRT = 8,
    parameter int CNT_W    = 4
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        flush,
    input  logic        req_valid,
    output logic        req_ready,
    input  logic [2:0]  req_op,
    input  logic [31:0] req_rs1,
    input  logic [31:0] req_rs2,
    input  logic [4:0]  req_rd,
    output logic [31:0] fpu_rs1,
    output logic [31:0] fpu_rs2,
    output logic [1:0]  fpu_control,
    output logic        fpu_sel,
    input  logic [31:0] fpu_result,
    output logic        rsp_valid,
    input  logic        rsp_ready,
    output logic [31:0] rsp_data,
    output logic [4:0]  rsp_rd,
    output logic        rsp_illegal,
    output logic        busy
`ifdef FPU_PERF_CNT_EN
    ,
    output logic [31:0] perf_ops,
    output logic [31:0] perf_stall
`endif
);

    state_t           state, state_nxt;
    logic [CNT_W-1:0] cnt;
    logic             accept;
    logic             req_legal;

    function automatic logic [CNT_W-1:0] hold_cycles(input logic [2:0] op);
        case (op)
            OP_MUL:  return CNT_W'(LAT_MUL - 1);
            OP_DIV:  return CNT_W'(LAT_DIV - 1);
            OP_SQRT: return CNT_W'(LAT_SQRT - 1);
            default: return CNT_W'(LAT_ADD - 1);
        endcase
    endfunction

    assign req_ready = !flush && (state == ST_IDLE || (state == ST_DONE && rsp_ready));
    assign accept    = req_valid && req_ready;
    assign req_legal = op_is_legal(req_op);
    assign rsp_valid = (state == ST_DONE);
    assign busy      = (state != ST_IDLE);

    always_ff @(posedge clk) begin
        if (!rst_n) state <= ST_IDLE;
        else        state <= state_nxt;
    end

    always_comb begin
        state_nxt = state;
        case (state)
            ST_IDLE: if (accept) state_nxt = req_legal ? ST_EXEC : ST_DONE;
            ST_EXEC: if (cnt == '0) state_nxt = ST_DONE;
            ST_DONE: begin
                if (accept)         state_nxt = req_legal ? ST_EXEC : ST_DONE;
                else if (rsp_ready) state_nxt = ST_IDLE;
            end
            default: state_nxt = ST_IDLE;
        endcase
        if (flush) state_nxt = ST_IDLE;
    end

    // FPU inputs move only on a legal accept so the multicycle paths see stable operands.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            cnt         <= '0;
            fpu_rs1     <= '0;
            fpu_rs2     <= '0;
            fpu_control <= FPU_ADDSUB;
            fpu_sel     <= 1'b0;
            rsp_data    <= '0;
            rsp_rd      <= '0;
            rsp_illegal <= 1'b0;
        end else if (flush) begin
            cnt <= '0;
        end else if (accept) begin
            rsp_rd <= req_rd;
            if (req_legal) begin
                fpu_rs1     <= req_rs1;
                fpu_rs2     <= (req_op == OP_SQRT) ? 32'h0 : req_rs2;
                fpu_control <= op_to_ctrl(req_op);
                fpu_sel     <= (req_op == OP_SUB);
                cnt         <= hold_cycles(req_op);
                rsp_illegal <= 1'b0;
            end else begin
                cnt         <= '0;
                rsp_data    <= CANON_NAN;
                rsp_illegal <= 1'b1;
            end
        end else if (state == ST_EXEC) begin
            if (cnt == '0) rsp_data <= fpu_result;
            else           cnt      <= cnt - 1'b1;
        end
    end

`ifdef FPU_PERF_CNT_EN
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            perf_ops   <= '0;
            perf_stall <= '0;
        end else begin
            if (rsp_valid && rsp_ready) perf_ops   <= perf_ops + 32'd1;
            if (req_valid && !req_ready) perf_stall <= perf_stall + 32'd1;
        end
    end
`endif

endmodule

// File: tb/tb_fpu_issue_ctrl.sv
// Directed bench for fpu_issue_ctrl with a behavioural FPU stub and a response scoreboard.
`timescale 1ns/1ps
module tb_fpu_issue_ctrl;

    localparam int PERIOD = 10;

    logic        clk = 1'b0;
    logic        rst_n, flush, req_valid, req_ready;
    logic [2:0]  req_op;
    logic [31:0] req_rs1, req_rs2;
    logic [4:0]  req_rd;
    logic [31:0] fpu_rs1, fpu_rs2, fpu_result;
    logic [1:0]  fpu_control;
    logic        fpu_sel;
    logic        rsp_valid, rsp_ready, rsp_illegal, busy;
    logic [31:0] rsp_data;
    logic [4:0]  rsp_rd;
`ifdef FPU_PERF_CNT_EN
    logic [31:0] perf_ops, perf_stall;
`endif

    fpu_issue_ctrl dut (
        .clk(clk), .rst_n(rst_n), .flush(flush),
        .req_valid(req_valid), .req_ready(req_ready), .req_op(req_op),
        .req_rs1(req_rs1), .req_rs2(req_rs2), .req_rd(req_rd),
        .fpu_rs1(fpu_rs1), .fpu_rs2(fpu_rs2), .fpu_control(fpu_control), .fpu_sel(fpu_sel),
        .fpu_result(fpu_result),
        .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_data(rsp_data),
        .rsp_rd(rsp_rd), .rsp_illegal(rsp_illegal), .busy(busy)
`ifdef FPU_PERF_CNT_EN
        , .perf_ops(perf_ops), .perf_stall(perf_stall)
`endif
    );

    always #(PERIOD/2) clk = ~clk;

    int n_vec = 0;
    int n_err = 0;

    typedef struct {
        logic [31:0] data;
        logic [4:0]  rd;
        logic        ill;
    } exp_t;
    exp_t exp_q[$];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    // Behavioural FPU: result is X until its inputs have been stable for the op's latency.
    time         t_chg = 0;
    logic [31:0] stub_val;
    int          stub_lat;

    always @(fpu_rs1 or fpu_rs2 or fpu_control or fpu_sel) t_chg = $time;

    always_comb begin
        stub_val = 32'h0;
        case (fpu_control)
            2'b00: begin
                stub_lat = 1;
                if (!fpu_sel && fpu_rs1 == 32'h3F800000 && fpu_rs2 == 32'h40000000) stub_val = 32'h40400000;
                if (fpu_sel && fpu_rs1 == 32'h40400000 && fpu_rs2 == 32'h3F800000)  stub_val = 32'h40000000;
            end
            2'b01: begin
                stub_lat = 2;
                if (fpu_rs1 == 32'h40000000 && fpu_rs2 == 32'h40400000) stub_val = 32'h40C00000;
            end
            2'b10: begin
                stub_lat = 8;
                if (fpu_rs1 == 32'h40C00000 && fpu_rs2 == 32'h40000000) stub_val = 32'h40400000;
            end
            default: begin
                stub_lat = 8;
                if (fpu_rs1 == 32'h41C80000) stub_val = 32'h40A00000;
            end
        endcase
    end

    always @(negedge clk) begin
        if ($time - t_chg >= time'((stub_lat - 1) * PERIOD + PERIOD / 2)) fpu_result = stub_val;
        else fpu_result = 'x;
    end

    // Monitor: every retired response is checked against the head of the expectation queue.
    always @(negedge clk) begin
        if (rst_n && rsp_valid && rsp_ready && !flush) begin
            if (exp_q.size() == 0) begin
                chk("unexpected_rsp", rsp_data, 32'hFFFFFFFF);
            end else begin
                exp_t e;
                e = exp_q.pop_front();
                chk("rsp_data", rsp_data, e.data);
                chk("rsp_rd", {27'd0, rsp_rd}, {27'd0, e.rd});
                chk("rsp_illegal", {31'd0, rsp_illegal}, {31'd0, e.ill});
            end
        end
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic drive(input logic [2:0] op, input logic [31:0] a, input logic [31:0] b, input logic [4:0] rd);
        req_valid = 1'b1;
        req_op    = op;
        req_rs1   = a;
        req_rs2   = b;
        req_rd    = rd;
    endtask

    task automatic expect_rsp(input logic [31:0] d, input logic [4:0] rd, input logic ill);
        exp_t e;
        e.data = d;
        e.rd   = rd;
        e.ill  = ill;
        exp_q.push_back(e);
    endtask

    task automatic wait_rsp(output int n);
        n = 0;
        while (!rsp_valid && n < 30) begin
            step();
            n++;
        end
        if (n >= 30) chk("rsp_timeout", 32'(n), 32'd0);
    endtask

    initial begin
        #(PERIOD * 5000);
        $display("FAIL global_timeout: got running expected finished");
        $fatal(1);
    end

    initial begin
        int          n;
        logic        bad;
        logic [67:0] snap;
        logic [31:0] stall0;

        rst_n = 1'b0; flush = 1'b0; req_valid = 1'b0; rsp_ready = 1'b1;
        req_op = 3'd0; req_rs1 = '0; req_rs2 = '0; req_rd = '0;
        step(); step();
        chk("rst_req_ready", {31'd0, req_ready}, 32'd1);
        chk("rst_valid_busy", {30'd0, rsp_valid, busy}, 32'd0);
        chk("rst_fpu", fpu_rs1 | fpu_rs2 | {29'd0, fpu_control, fpu_sel}, 32'd0);
        chk("rst_rsp", rsp_data | {26'd0, rsp_illegal, rsp_rd}, 32'd0);
        rst_n = 1'b1;
        step();

        // add 1.0 + 2.0
        drive(3'b000, 32'h3F800000, 32'h40000000, 5'd1);
        expect_rsp(32'h40400000, 5'd1, 1'b0);
        step();
        req_valid = 1'b0;
        chk("add_ctrl", {29'd0, fpu_control, fpu_sel}, 32'd0);
        chk("add_rs1", fpu_rs1, 32'h3F800000);
        wait_rsp(n);
        chk("add_latency", 32'(n), 32'd1);
        step();

        // sub then div back-to-back
        drive(3'b001, 32'h40400000, 32'h3F800000, 5'd2);
        expect_rsp(32'h40000000, 5'd2, 1'b0);
        step();
        chk("sub_sel", {31'd0, fpu_sel}, 32'd1);
        drive(3'b011, 32'h40C00000, 32'h40000000, 5'd3);
        expect_rsp(32'h40400000, 5'd3, 1'b0);
        step();
        chk("sub_done_ready", {30'd0, rsp_valid, req_ready}, 32'd3);
        step();
        req_valid = 1'b0;
        chk("div_no_bubble", {29'd0, busy, rsp_valid, fpu_control == 2'b10}, 32'b101);
        wait_rsp(n);
        chk("div_latency", 32'(n), 32'd8);
        step();

        // sqrt 25
        drive(3'b100, 32'h41C80000, 32'h12345678, 5'd4);
        expect_rsp(32'h40A00000, 5'd4, 1'b0);
        step();
        req_valid = 1'b0;
        chk("sqrt_rs2", fpu_rs2, 32'h0);
        chk("sqrt_ctrl", {30'd0, fpu_control}, 32'd3);
        snap = {fpu_rs1, fpu_rs2, fpu_control, fpu_sel, 1'b0};
        bad = 1'b0;
        n = 0;
        while (!rsp_valid && n < 30) begin
            if (snap != {fpu_rs1, fpu_rs2, fpu_control, fpu_sel, 1'b0} || req_ready) bad = 1'b1;
            step();
            n++;
        end
        chk("sqrt_latency", 32'(n), 32'd8);
        chk("sqrt_stable", {31'd0, bad}, 32'd0);
        step();

        // mul under backpressure, with a queued add stalled behind it
        rsp_ready = 1'b0;
        drive(3'b010, 32'h40000000, 32'h40400000, 5'd5);
        expect_rsp(32'h40C00000, 5'd5, 1'b0);
        step();
        req_valid = 1'b0;
        wait_rsp(n);
        chk("mul_latency", 32'(n), 32'd2);
        drive(3'b000, 32'h3F800000, 32'h40000000, 5'd6);
        expect_rsp(32'h40400000, 5'd6, 1'b0);
`ifdef FPU_PERF_CNT_EN
        stall0 = perf_stall;
`else
        stall0 = 32'd0;
`endif
        bad = 1'b0;
        for (int i = 0; i < 5; i++) begin
            if (!rsp_valid || req_ready || rsp_data !== 32'h40C00000) bad = 1'b1;
            step();
        end
        chk("mul_held", {31'd0, bad}, 32'd0);
`ifdef FPU_PERF_CNT_EN
        chk("perf_stall", perf_stall - stall0, 32'd5);
`endif
        rsp_ready = 1'b1;
        step();
        req_valid = 1'b0;
        chk("bp_accept_busy", {30'd0, busy, rsp_valid}, 32'b10);
        wait_rsp(n);
        step();

        // flush in the third EXEC cycle of a div
        drive(3'b011, 32'h40C00000, 32'h40000000, 5'd7);
        step();
        req_valid = 1'b0;
        step(); step();
        flush = 1'b1;
        drive(3'b000, 32'h3F800000, 32'h40000000, 5'd8);
        expect_rsp(32'h40400000, 5'd8, 1'b0);
        chk("flush_req_ready", {31'd0, req_ready}, 32'd0);
        step();
        flush = 1'b0;
        chk("flush_idle", {30'd0, busy, rsp_valid}, 32'd0);
        step();
        req_valid = 1'b0;
        chk("post_flush_accept", {31'd0, busy}, 32'd1);
        wait_rsp(n);
        chk("post_flush_latency", 32'(n), 32'd1);
        step();

        // illegal op
        snap = {fpu_rs1, fpu_rs2, fpu_control, fpu_sel, 1'b0};
        drive(3'b101, 32'hCAFEF00D, 32'h01234567, 5'd9);
        expect_rsp(32'h7FC00000, 5'd9, 1'b1);
        step();
        req_valid = 1'b0;
        chk("ill_valid", {31'd0, rsp_valid}, 32'd1);
        chk("ill_fpu_hold", {31'd0, snap == {fpu_rs1, fpu_rs2, fpu_control, fpu_sel, 1'b0}}, 32'd1);
        step();

        // reset mid-EXEC
        drive(3'b011, 32'h40C00000, 32'h40000000, 5'd10);
        step();
        req_valid = 1'b0;
        step(); step();
        rst_n = 1'b0;
        step();
        chk("mid_rst_state", {29'd0, req_ready, busy, rsp_valid}, 32'b100);
        chk("mid_rst_fpu", fpu_rs1 | fpu_rs2 | {29'd0, fpu_control, fpu_sel}, 32'd0);
        chk("mid_rst_rsp", rsp_data | {27'd0, rsp_rd}, 32'd0);
        rst_n = 1'b1;
        for (int i = 0; i < 10; i++) step();
        chk("queue_empty", 32'(exp_q.size()), 32'd0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
